// File: rtl/ibex_rvfi_trace_buf.sv
// Purpose: captures RVFI retirements into a ring FIFO under an arm/trigger/stop FSM.
// Latency: a record pushed into an empty FIFO appears on rec_o/rec_valid_o one cycle later.
// Backpressure: rec_o holds while rec_ready_i=0; when full, wraps (overwrite oldest) or stops.
//
// Ports: clk_i/rst_ni clock and async active-low reset; rvfi_* retirement stream;
//   arm_i/stop_i/trig_en_i/trig_pc_i capture control; rec_valid_o/rec_ready_i/rec_o
//   drain port; level_o occupancy; drop_cnt_o saturating drop count; state_o FSM state.
// Optional: define IBEX_TRACE_BUF_TIMESTAMP_EN to prepend a 32-bit cycle timestamp.
module ibex_rvfi_trace_buf #(
    parameter int unsigned Depth       = 16,
    parameter bit          PcOnly      = 1'b0,
    parameter bit          StopOnFull  = 1'b0,
    parameter int unsigned PostTrigCnt = 8,
`ifdef IBEX_TRACE_BUF_TIMESTAMP_EN
    localparam int unsigned TsW        = 32,
`else
    localparam int unsigned TsW        = 0,
`endif
    localparam int unsigned RecW       = (PcOnly ? 32 : 128) + TsW,
    localparam int unsigned LvlW       = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rvfi_valid_i,
    input  logic [63:0]     rvfi_order_i,
    input  logic [31:0]     rvfi_insn_i,
    input  logic            rvfi_trap_i,
    input  logic            rvfi_intr_i,
    input  logic [1:0]      rvfi_mode_i,
    input  logic [4:0]      rvfi_rd_addr_i,
    input  logic [31:0]     rvfi_rd_wdata_i,
    input  logic [31:0]     rvfi_pc_rdata_i,
    input  logic            arm_i,
    input  logic            stop_i,
    input  logic            trig_en_i,
    input  logic [31:0]     trig_pc_i,
    output logic            rec_valid_o,
    input  logic            rec_ready_i,
    output logic [RecW-1:0] rec_o,
    output logic [LvlW-1:0] level_o,
    output logic [15:0]     drop_cnt_o,
    output logic [1:0]      state_o
);

    localparam int unsigned      AW       = LvlW - 1;
    localparam int unsigned      BaseW    = PcOnly ? 32 : 128;
    localparam logic [LvlW-1:0]  FullLvl  = LvlW'(Depth);
    // Counter holds the number of records still to capture after the current push.
    localparam logic [31:0]      PostLoad = (PostTrigCnt == 0) ? 32'd0 : 32'(PostTrigCnt - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StStopped = 2'd3
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [LvlW-1:0] level_q, level_nxt;
    logic [31:0]     post_cnt_q;
    logic [RecW-1:0] mem [Depth];

    logic [BaseW-1:0] base_rec;
    logic [RecW-1:0]  new_rec;
    logic trig_hit, push, pop, full;
    logic do_write, adv_rd, drop, sof_discard;

    if (PcOnly) begin : g_pc_rec
        assign base_rec = rvfi_pc_rdata_i;
        logic unused_fields;
        assign unused_fields = ^{rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_intr_i,
                                 rvfi_mode_i, rvfi_rd_addr_i, rvfi_rd_wdata_i};
    end else begin : g_full_rec
        assign base_rec = {rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i, rvfi_rd_addr_i,
                           rvfi_trap_i, rvfi_intr_i, rvfi_mode_i, rvfi_order_i[22:0]};
        logic unused_order;
        assign unused_order = ^rvfi_order_i[63:23];
    end

`ifdef IBEX_TRACE_BUF_TIMESTAMP_EN
    logic [31:0] ts_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= 32'd0;
        else         ts_q <= ts_q + 32'd1;
    end
    assign new_rec = {ts_q, base_rec};
`else
    assign new_rec = base_rec;
`endif

    assign trig_hit = !trig_en_i || (rvfi_pc_rdata_i == trig_pc_i);
    // stop_i suppresses a coincident retirement.
    assign push = rvfi_valid_i && !stop_i &&
                  ((state_q == StCapture) || ((state_q == StArmed) && trig_hit));
    assign pop  = rec_valid_o && rec_ready_i;
    assign full = (level_q == FullLvl);

    always_comb begin
        do_write    = 1'b0;
        adv_rd      = pop;
        drop        = 1'b0;
        sof_discard = 1'b0;
        if (push) begin
            if (!full || pop) begin
                do_write = 1'b1;
            end else if (!StopOnFull) begin
                // Overwrite: write slot equals head when full, so head moves on.
                do_write = 1'b1;
                adv_rd   = 1'b1;
                drop     = 1'b1;
            end else begin
                drop        = 1'b1;
                sof_discard = 1'b1;
            end
        end
        rd_ptr_nxt = adv_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_nxt  = level_q;
        if (do_write && !adv_rd)      level_nxt = level_q + 1'b1;
        else if (!do_write && adv_rd) level_nxt = level_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (do_write) mem[wr_ptr_q] <= new_rec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            post_cnt_q  <= 32'd0;
            drop_cnt_o  <= 16'd0;
            rec_valid_o <= 1'b0;
            rec_o       <= '0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
            rd_ptr_q    <= rd_ptr_nxt;
            level_q     <= level_nxt;
            rec_valid_o <= (level_nxt != '0);
            // The new head is the slot being written when it lands at the read pointer.
            if (do_write && (rd_ptr_nxt == wr_ptr_q)) rec_o <= new_rec;
            else                                      rec_o <= mem[rd_ptr_nxt];

            if (arm_i && !stop_i)                   drop_cnt_o <= 16'd0;
            else if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;

            if (stop_i) begin
                state_q <= StStopped;
            end else begin
                case (state_q)
                    StIdle, StStopped: begin
                        if (arm_i) state_q <= StArmed;
                    end
                    StArmed: begin
                        if (push) begin
                            post_cnt_q <= PostLoad;
                            if (sof_discard || (PostTrigCnt == 1)) state_q <= StStopped;
                            else                                   state_q <= StCapture;
                        end
                    end
                    StCapture: begin
                        if (sof_discard) begin
                            state_q <= StStopped;
                        end else if (push && (PostTrigCnt != 0)) begin
                            post_cnt_q <= post_cnt_q - 32'd1;
                            if (post_cnt_q == 32'd1) state_q <= StStopped;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign level_o = level_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
module tb_ibex_rvfi_trace_buf;

    localparam int D = 4;
    localparam int ST_IDLE = 0, ST_ARMED = 1, ST_CAP = 2, ST_STOP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  sel;
    logic        valid, arm, stop, ready, trig_en;
    logic [63:0] order;
    logic [31:0] insn, wdata, pc, trig_pc;
    logic        trap, intr;
    logic [1:0]  mode;
    logic [4:0]  rd;
    logic [2:0]  valid_v, arm_v, stop_v, ready_v;

    assign valid_v = valid ? (3'b001 << sel) : 3'b000;
    assign arm_v   = arm   ? (3'b001 << sel) : 3'b000;
    assign stop_v  = stop  ? (3'b001 << sel) : 3'b000;
    assign ready_v = ready ? (3'b001 << sel) : 3'b000;

    logic         rv_w   [3];
    logic [127:0] rec_w  [3];
    logic [2:0]   lvl_w  [3];
    logic [15:0]  drop_w [3];
    logic [1:0]   st_w   [3];

    // Instance 0: wrap mode, no auto-stop.
    ibex_rvfi_trace_buf #(.Depth(D), .PcOnly(1'b0), .StopOnFull(1'b0), .PostTrigCnt(0)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid_v[0]), .rvfi_order_i(order),
        .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_mode_i(mode),
        .rvfi_rd_addr_i(rd), .rvfi_rd_wdata_i(wdata), .rvfi_pc_rdata_i(pc),
        .arm_i(arm_v[0]), .stop_i(stop_v[0]), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .rec_valid_o(rv_w[0]), .rec_ready_i(ready_v[0]), .rec_o(rec_w[0]),
        .level_o(lvl_w[0]), .drop_cnt_o(drop_w[0]), .state_o(st_w[0]));

    // Instance 1: stop when full.
    ibex_rvfi_trace_buf #(.Depth(D), .PcOnly(1'b0), .StopOnFull(1'b1), .PostTrigCnt(0)) u_sof (
        .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid_v[1]), .rvfi_order_i(order),
        .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_mode_i(mode),
        .rvfi_rd_addr_i(rd), .rvfi_rd_wdata_i(wdata), .rvfi_pc_rdata_i(pc),
        .arm_i(arm_v[1]), .stop_i(stop_v[1]), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .rec_valid_o(rv_w[1]), .rec_ready_i(ready_v[1]), .rec_o(rec_w[1]),
        .level_o(lvl_w[1]), .drop_cnt_o(drop_w[1]), .state_o(st_w[1]));

    // Instance 2: wrap mode, auto-stop after two records.
    ibex_rvfi_trace_buf #(.Depth(D), .PcOnly(1'b0), .StopOnFull(1'b0), .PostTrigCnt(2)) u_trig (
        .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid_v[2]), .rvfi_order_i(order),
        .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_mode_i(mode),
        .rvfi_rd_addr_i(rd), .rvfi_rd_wdata_i(wdata), .rvfi_pc_rdata_i(pc),
        .arm_i(arm_v[2]), .stop_i(stop_v[2]), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .rec_valid_o(rv_w[2]), .rec_ready_i(ready_v[2]), .rec_o(rec_w[2]),
        .level_o(lvl_w[2]), .drop_cnt_o(drop_w[2]), .state_o(st_w[2]));

    // Reference model: a queue of records plus capture state.
    logic [127:0] mq[$];
    int m_st, m_drop, m_rem, m_ptc;
    bit m_sof;
    int total = 0, bad = 0;

    function automatic logic [127:0] mk_rec();
        return {pc, insn, wdata, rd, trap, intr, mode, order[22:0]};
    endfunction

    task automatic model_step();
        int s0;
        bit hit, pu, acc;
        s0 = m_st;
        if (mq.size() != 0 && ready) void'(mq.pop_front());
        hit = !trig_en || (pc == trig_pc);
        pu  = valid && !stop && (s0 == ST_CAP || (s0 == ST_ARMED && hit));
        if (pu) begin
            acc = 1'b1;
            if (s0 == ST_ARMED) begin
                m_st  = ST_CAP;
                m_rem = m_ptc;
            end
            if (mq.size() == D) begin
                if (m_drop < 65535) m_drop++;
                if (m_sof) begin
                    acc  = 1'b0;
                    m_st = ST_STOP;
                end else begin
                    void'(mq.pop_front());
                end
            end
            if (acc) begin
                mq.push_back(mk_rec());
                if (m_ptc != 0) begin
                    m_rem--;
                    if (m_rem == 0) m_st = ST_STOP;
                end
            end
        end
        if (arm && !stop) begin
            m_drop = 0;
            if (s0 == ST_IDLE || s0 == ST_STOP) m_st = ST_ARMED;
        end
        if (stop) m_st = ST_STOP;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 128'(rv_w[sel]), 128'(mq.size() != 0));
        chk({tag, ".level"}, 128'(lvl_w[sel]), 128'(mq.size()));
        chk({tag, ".state"}, 128'(st_w[sel]), 128'(m_st));
        chk({tag, ".drop"},  128'(drop_w[sel]), 128'(m_drop));
        if (mq.size() != 0) chk({tag, ".rec"}, rec_w[sel], mq[0]);
    endtask

    task automatic step(input logic v, input logic [31:0] p, input logic a, input logic s,
                        input logic r, input string tag);
        valid = v; pc = p; arm = a; stop = s; ready = r;
        order = {$urandom, $urandom};
        insn  = $urandom;
        wdata = $urandom;
        rd    = 5'($urandom);
        trap  = 1'($urandom);
        intr  = 1'($urandom);
        mode  = 2'($urandom);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic model_clear();
        mq.delete();
        m_st = ST_IDLE; m_drop = 0; m_rem = 0;
    endtask

    task automatic do_reset(input logic [1:0] s, input bit sof, input int ptc);
        sel = s; m_sof = sof; m_ptc = ptc;
        valid = 0; arm = 0; stop = 0; ready = 0;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");
        chk("reset.rec0", rec_w[sel], 128'd0);
    endtask

    initial begin
        trig_en = 1'b0; trig_pc = 32'h0;
        pc = 0; order = 0; insn = 0; wdata = 0; rd = 0; trap = 0; intr = 0; mode = 0;

        // Basic capture and drain.
        do_reset(2'd0, 1'b0, 0);
        step(0, 0, 1, 0, 0, "a_arm");
        chk("a_armed", 128'(st_w[0]), 128'(ST_ARMED));
        step(1, 32'h100, 0, 0, 0, "a_r0");
        step(1, 32'h104, 0, 0, 0, "a_r1");
        step(1, 32'h108, 0, 0, 0, "a_r2");
        chk("a_level3", 128'(lvl_w[0]), 128'd3);
        chk("a_head0", 128'(rec_w[0][127:96]), 128'h100);
        for (int i = 1; i < 3; i++) begin
            step(0, 0, 0, 0, 1, "a_pop");
            chk("a_head", 128'(rec_w[0][127:96]), 128'(32'h100 + 4 * i));
        end
        step(0, 0, 0, 0, 1, "a_pop_last");
        chk("a_empty", 128'(rv_w[0]), 128'd0);

        // Wrap: six retirements into four entries.
        do_reset(2'd0, 1'b0, 0);
        step(0, 0, 1, 0, 0, "b_arm");
        for (int i = 0; i < 6; i++) step(1, 32'(4 * i), 0, 0, 0, "b_ret");
        chk("b_level", 128'(lvl_w[0]), 128'd4);
        chk("b_drop", 128'(drop_w[0]), 128'd2);
        for (int i = 0; i < 4; i++) begin
            chk("b_drain_pc", 128'(rec_w[0][127:96]), 128'(32'h8 + 4 * i));
            step(0, 0, 0, 0, 1, "b_pop");
        end
        chk("b_empty", 128'(rv_w[0]), 128'd0);

        // Stop on full.
        do_reset(2'd1, 1'b1, 0);
        step(0, 0, 1, 0, 0, "c_arm");
        for (int i = 0; i < 6; i++) step(1, 32'(4 * i), 0, 0, 0, "c_ret");
        chk("c_level", 128'(lvl_w[1]), 128'd4);
        chk("c_drop", 128'(drop_w[1]), 128'd1);
        chk("c_state", 128'(st_w[1]), 128'(ST_STOP));
        for (int i = 0; i < 4; i++) begin
            chk("c_drain_pc", 128'(rec_w[1][127:96]), 128'(4 * i));
            step(0, 0, 0, 0, 1, "c_pop");
        end

        // PC trigger with post-trigger auto-stop.
        do_reset(2'd2, 1'b0, 2);
        trig_en = 1'b1; trig_pc = 32'h200;
        step(0, 0, 1, 0, 0, "d_arm");
        step(1, 32'h1FC, 0, 0, 0, "d_r0");
        step(1, 32'h200, 0, 0, 0, "d_r1");
        step(1, 32'h204, 0, 0, 0, "d_r2");
        step(1, 32'h208, 0, 0, 0, "d_r3");
        chk("d_level", 128'(lvl_w[2]), 128'd2);
        chk("d_state", 128'(st_w[2]), 128'(ST_STOP));
        chk("d_head0", 128'(rec_w[2][127:96]), 128'h200);
        step(0, 0, 0, 0, 1, "d_pop");
        chk("d_head1", 128'(rec_w[2][127:96]), 128'h204);
        trig_en = 1'b0;

        // Full FIFO push+pop, then arm+stop together.
        do_reset(2'd0, 1'b0, 0);
        step(0, 0, 1, 0, 0, "e_arm");
        for (int i = 0; i < 4; i++) step(1, 32'(32'h300 + 4 * i), 0, 0, 0, "e_fill");
        step(1, 32'h310, 0, 0, 1, "e_pushpop");
        chk("e_level", 128'(lvl_w[0]), 128'd4);
        chk("e_drop", 128'(drop_w[0]), 128'd0);
        step(0, 0, 1, 1, 0, "e_armstop");
        chk("e_stopwins", 128'(st_w[0]), 128'(ST_STOP));
        step(1, 32'h320, 0, 0, 0, "e_stopped_ret");

        // Asynchronous reset mid-capture.
        do_reset(2'd0, 1'b0, 0);
        step(0, 0, 1, 0, 0, "f_arm");
        for (int i = 0; i < 5; i++) step(1, 32'(32'h400 + 4 * i), 0, 0, 0, "f_ret");
        step(0, 0, 0, 0, 1, "f_pop");
        chk("f_pre_drop", 128'(drop_w[0]), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_rst_level", 128'(lvl_w[0]), 128'd0);
        chk("f_rst_valid", 128'(rv_w[0]), 128'd0);
        chk("f_rst_state", 128'(st_w[0]), 128'(ST_IDLE));
        chk("f_rst_drop", 128'(drop_w[0]), 128'd0);
        chk("f_rst_rec", rec_w[0], 128'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic on each configuration.
        for (int s = 0; s < 3; s++) begin
            do_reset(2'(s), (s == 1), (s == 2) ? 2 : 0);
            trig_en = (s == 2);
            trig_pc = 32'h8;
            for (int n = 0; n < 400; n++) begin
                step(1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 7)) << 2,
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 2) == 0),
                     "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
